sbox_share_driver: RTL and testbench

//  Host-side partner of the 2-share, 2-stage masked AES S-box: splits unmasked bytes into two

---
 rtl/sbox_share_driver.sv | 96 +++++++++
 tb/tb_sbox_share_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_driver.sv
// Host-side driver for a 2-share masked AES S-box: masks input bytes, supplies fresh
// randomness every cycle, tracks S-box latency and recombines the output shares.
module sbox_share_driver #(
    parameter int unsigned SBOX_LAT = 2,
    parameter logic [63:0] ZERO_SUB = 64'h9E3779B97F4A7C15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_valid,
    input  logic [63:0] seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic [15:0] out_count,
    output logic [45:0] PRNG,
    output logic [7:0]  inp0,
    output logic [7:0]  inp1,
    input  logic [7:0]  F0,
    input  logic [7:0]  F1
);

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] s;
    logic [63:0] s_step;
    logic [63:0] s_load;
    logic        accept;
    logic [SBOX_LAT:0] vpipe;

    // Sequential xorshift: each shift applies to the already-updated value.
    function automatic logic [63:0] xorshift(input logic [63:0] v);
        logic [63:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    always_comb begin
        state_next = state;
        if (seed_valid) begin
            state_next = RUN;
        end
    end

    always_comb begin
        s_step = xorshift(s);
        s_load = (seed == '0) ? ZERO_SUB : seed;
    end

    assign in_ready = (state == RUN) && !seed_valid;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= UNSEEDED;
            s         <= '0;
            vpipe     <= '0;
            PRNG      <= '0;
            inp0      <= '0;
            inp1      <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_count <= '0;
        end else begin
            state <= state_next;
            if (seed_valid) begin
                s <= s_load;
            end else if (state == RUN) begin
                s <= s_step;
            end

            // Idle RUN cycles still refresh the shares with a masked 0x00.
            if (state == RUN) begin
                PRNG <= s[45:0];
                inp1 <= s[53:46];
                inp0 <= s[53:46] ^ (accept ? in_byte : 8'h00);
            end

            vpipe     <= {vpipe[SBOX_LAT-1:0], accept};
            out_valid <= vpipe[SBOX_LAT];
            if (vpipe[SBOX_LAT]) begin
                out_byte  <= F0 ^ F1;
                out_count <= out_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sbox_share_driver.sv
// Self-checking bench for sbox_share_driver: behavioural masked S-box environment,
// queue-based scoreboard, fixed vectors and randomized traffic.
module tb_sbox_share_driver;

    localparam logic [63:0] ZS = 64'h9E3779B97F4A7C15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_valid = 1'b0;
    logic [63:0] seed = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic [15:0] out_count;
    logic [45:0] PRNG;
    logic [7:0]  inp0;
    logic [7:0]  inp1;
    logic [7:0]  F0;
    logic [7:0]  F1;

    always #5 clk = ~clk;

    sbox_share_driver #(.SBOX_LAT(2), .ZERO_SUB(ZS)) dut (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .out_valid(out_valid), .out_byte(out_byte), .out_count(out_count),
        .PRNG(PRNG), .inp0(inp0), .inp1(inp1), .F0(F0), .F1(F1)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // AES S-box from first principles: GF(2^8) inverse then affine map.
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            b = b >> 1;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, x[7:0]);
            end
            sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    end

    // Environment: 2-stage masked S-box producing freshly re-masked output shares.
    logic [7:0] st1 = '0, st2 = '0, m1 = '0, m2 = '0;
    always @(posedge clk) begin
        st1 <= sbox_tab[inp0 ^ inp1];
        m1  <= 8'($urandom);
        st2 <= st1;
        m2  <= m1;
    end
    assign F0 = st2 ^ m2;
    assign F1 = m2;

    // Reference model: queue of pending results with due edge numbers.
    typedef struct { logic [7:0] b; int due; } pend_t;
    pend_t       q[$];
    int          cyc = 0;
    bit          seeded = 0;
    logic [63:0] s_m = '0;
    logic [45:0] e_prng = '0;
    logic [7:0]  e_inp1 = '0, e_xor = '0, e_byte = '0;
    logic        e_valid = 1'b0;
    logic [15:0] e_count = '0;

    function automatic logic [63:0] xs(input logic [63:0] v);
        v = v ^ (v << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    always @(posedge clk) begin
        bit acc;
        cyc++;
        if (!rst_n) begin
            seeded = 0; s_m = '0; e_prng = '0; e_inp1 = '0; e_xor = '0;
            e_byte = '0; e_valid = 1'b0; e_count = '0; q.delete();
        end else begin
            acc = seeded && !seed_valid && in_valid;
            e_valid = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e_valid = 1'b1;
                e_byte  = sbox_tab[q[0].b];
                e_count = e_count + 16'd1;
                void'(q.pop_front());
            end
            if (seeded) begin
                e_prng = s_m[45:0];
                e_inp1 = s_m[53:46];
                e_xor  = acc ? in_byte : 8'h00;
            end
            if (acc) q.push_back('{b: in_byte, due: cyc + 3});
            if (seed_valid) begin
                s_m = (seed == 64'd0) ? ZS : seed;
                seeded = 1;
            end else if (seeded) begin
                s_m = xs(s_m);
            end
        end
    end

    bit mon_en = 0;
    int run_len = 0, max_run = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 64'(out_valid), 64'(e_valid));
            check("out_byte", 64'(out_byte), 64'(e_byte));
            check("out_count", 64'(out_count), 64'(e_count));
            check("PRNG", 64'(PRNG), 64'(e_prng));
            check("inp1", 64'(inp1), 64'(e_inp1));
            check("share_xor", 64'(inp0 ^ inp1), 64'(e_xor));
            run_len = out_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
        end
    end

    task automatic drive(input bit v, input logic [7:0] b, input bit sv, input logic [63:0] sd);
        @(negedge clk);
        #1;
        in_valid = v; in_byte = b; seed_valid = sv; seed = sd;
        #1;
        check("in_ready", 64'(in_ready), 64'(seeded && !sv));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0; in_valid = 1'b0; seed_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct packed { logic [7:0] din; logic [7:0] dout; } vec_t;
    vec_t vecs [6];

    initial begin
        int lat;
        logic [15:0] c0;
        logic [45:0] prev;
        vecs[0] = '{din: 8'h00, dout: 8'h63};
        vecs[1] = '{din: 8'h53, dout: 8'hED};
        vecs[2] = '{din: 8'hFF, dout: 8'h16};
        vecs[3] = '{din: 8'h01, dout: 8'h7C};
        vecs[4] = '{din: 8'h10, dout: 8'hCA};
        vecs[5] = '{din: 8'h80, dout: 8'hCD};

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_byte", 64'(out_byte), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_PRNG", 64'(PRNG), 64'd0);
        check("rst_inp0", 64'(inp0), 64'd0);
        check("rst_inp1", 64'(inp1), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        #1;
        rst_n = 1'b1;
        mon_en = 1;

        // Unseeded: offers are refused.
        repeat (3) drive(1, 8'hAA, 0, '0);
        drive(0, 8'h00, 1, 64'h1);

        foreach (vecs[i]) begin
            drive(1, vecs[i].din, 0, '0);
            drive(0, 8'h00, 0, '0);
            check("port_xor", 64'(inp0 ^ inp1), 64'(vecs[i].din));
            lat = 9;
            for (int k = 1; k <= 8; k++) begin
                drive(0, 8'h00, 0, '0);
                if (out_valid) begin
                    lat = k;
                    break;
                end
            end
            check("latency", 64'(lat), 64'd3);
            check("vec_out_byte", 64'(out_byte), 64'(vecs[i].dout));
            if (i == 0) check("count_first", 64'(out_count), 64'd1);
        end

        // Full table streamed back-to-back.
        repeat (4) drive(0, 8'h00, 0, '0);
        max_run = 0;
        for (int b = 0; b < 256; b++) drive(1, b[7:0], 0, '0);
        repeat (6) drive(0, 8'h00, 0, '0);
        check("stream_run", 64'(max_run), 64'd256);

        // All-zero seed substitutes the constant; PRNG moves every cycle.
        drive(0, 8'h00, 1, 64'd0);
        drive(0, 8'h00, 0, '0);
        drive(0, 8'h00, 0, '0);
        check("zero_sub_prng", 64'(PRNG), 64'(ZS[45:0]));
        check("zero_sub_inp1", 64'(inp1), 64'(ZS[53:46]));
        prev = PRNG;
        for (int k = 0; k < 8; k++) begin
            drive(0, 8'h00, 0, '0);
            check("prng_changes", 64'(PRNG != prev), 64'd1);
            prev = PRNG;
        end

        // Reseed in the middle of a held stream.
        c0 = out_count;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) drive(1, 8'(i + 8'h40), 1, 64'hDEADBEEF_0BADF00D);
            drive(1, 8'(i + 8'h40), 0, '0);
        end
        repeat (6) drive(0, 8'h00, 0, '0);
        check("reseed_count", 64'(16'(out_count - c0)), 64'd20);

        // Reset with two bytes in flight.
        drive(1, 8'h11, 0, '0);
        drive(1, 8'h22, 0, '0);
        drive(0, 8'h00, 0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) drive(0, 8'h00, 0, '0);
        check("post_reset_count", 64'(out_count), 64'd0);

        // Randomized traffic with occasional reseeds (sometimes zero) and resets.
        for (int n = 0; n < 1500; n++) begin
            bit sv;
            logic [63:0] sd;
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                sv = !seeded || ($urandom_range(0, 40) == 0);
                sd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
                drive($urandom_range(0, 3) != 0, 8'($urandom), sv, sd);
            end
        end
        repeat (6) drive(0, 8'h00, 0, '0);
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
